// File: rtl/axi4_pkg.sv
// Shared AXI4 types: burst and response encodings, write-master FSM states, default widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi4_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } wr_state_e;

endpackage

// File: rtl/axi4_burst_check.sv
// Combinational legality check of an AXI4 burst (addr, len, size, burst).
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
module axi4_burst_check
  import axi4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STRB_W = DATA_W_DEF / 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic              legal
);

  // Largest beat size the data bus can carry, as log2(bytes).
  localparam int SIZE_MAX = $clog2(STRB_W);

  logic [ADDR_W-1:0] align_mask;
  logic              aligned;
  logic              wrap_len_ok;
  logic              size_ok;
  logic              burst_ok;
  logic              is_wrap;

  // WRAP bursts need a power-of-two beat count and a beat-aligned start address.
  always_comb begin
    align_mask  = ~({ADDR_W{1'b1}} << size);
    aligned     = (addr & align_mask) == '0;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    size_ok     = size <= 3'(SIZE_MAX);
    burst_ok    = burst != 2'b11;
    is_wrap     = burst == WRAP;
    legal       = burst_ok && size_ok && (!is_wrap || (wrap_len_ok && aligned));
  end

endmodule

// File: rtl/axi4_write_master.sv
// AXI4 write initiator: one burst command plus local beat stream -> AW/W/B, one rsp pulse per command.
// Latency: N-beat burst completes in N+3 cycles after accept with a zero-wait slave.
// Backpressure: W is pass-through (wr_ready = WREADY in DATA); AW held until AWREADY; rsp has none.
module axi4_write_master
  import axi4_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  // local beats
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  // completion
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_id_err,
  // AXI write address
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ID_W-1:0]       AWID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  // AXI write data
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [ID_W-1:0]       WID,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WLAST,
  // AXI write response
  output logic                  BREADY,
  input  logic                  BVALID,
  input  logic [ID_W-1:0]       BID,
  input  logic [1:0]            BRESP
);

  wr_state_e  state;
  logic [7:0] beat_cnt;
  logic       cmd_legal;
  logic       in_data;

  axi4_burst_check #(
    .ADDR_W (ADDR_W),
    .STRB_W (DATA_W / 8)
  ) u_burst_check (
    .addr  (cmd_addr),
    .len   (cmd_len),
    .size  (cmd_size),
    .burst (cmd_burst),
    .legal (cmd_legal)
  );

  // W channel is a straight pass-through, gated so nothing leaks outside DATA.
  always_comb begin
    in_data   = state == DATA;
    cmd_ready = state == IDLE;
    WVALID    = in_data && wr_valid;
    wr_ready  = in_data && WREADY;
    WDATA     = wr_data;
    WSTRB     = wr_strb;
    WID       = AWID;
    WLAST     = beat_cnt == AWLEN;
  end

  // Transaction FSM with registered AW/B/rsp outputs; the AW* registers double as the captured command.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      beat_cnt   <= 8'd0;
      AWVALID    <= 1'b0;
      AWID       <= '0;
      AWADDR     <= '0;
      AWLEN      <= 8'd0;
      AWSIZE     <= 3'd0;
      AWBURST    <= 2'd0;
      BREADY     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_resp   <= 2'd0;
      rsp_id_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            AWID     <= cmd_id;
            AWADDR   <= cmd_addr;
            AWLEN    <= cmd_len;
            AWSIZE   <= cmd_size;
            AWBURST  <= cmd_burst;
            beat_cnt <= 8'd0;
            if (cmd_legal) begin
              AWVALID <= 1'b1;
              state   <= ADDR;
            end else begin
              // Rejected locally: report SLVERR without touching the bus.
              rsp_id     <= cmd_id;
              rsp_resp   <= SLVERR;
              rsp_id_err <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (WVALID && WREADY) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (WLAST) begin
              BREADY <= 1'b1;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (BVALID) begin
            BREADY     <= 1'b0;
            rsp_id     <= AWID;
            rsp_resp   <= BRESP;
            rsp_id_err <= BID != AWID;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
